// File: rtl/press_pkg.sv
// press_pkg: shared types and helpers for the push-button classifier.
//   press_state_t     per-channel press FSM state
//   press_params_ok   elaboration-time legality check of the classifier parameters
package press_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        LONG,
        RELEASE
    } press_state_t;

    // True when 1 <= debounce_p < long_min_t < 2**cnt_w and the synchroniser has >= 2 flops.
    function automatic bit press_params_ok(input int sync_stages, input int debounce_p,
                                           input int long_min_t, input int cnt_w);
        bit fits;
        fits = (cnt_w >= 31) || (long_min_t < (1 << cnt_w));
        return (sync_stages >= 2) && (debounce_p >= 1) && (debounce_p < long_min_t)
               && (cnt_w >= 1) && fits;
    endfunction

endpackage

// File: rtl/press_channel.sv
// press_channel: one button channel -- input synchroniser, debounce/classify FSM, sample counter.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   btn        raw asynchronous button level, 1 = pushed
//   pressed    1 while the press is accepted (HELD or LONG)
//   held_long  1 while the press has reached the LONG threshold
//   short_evt  1-cycle pulse when a SHORT press is released
//   long_evt   1-cycle pulse when a LONG press is released
module press_channel
    import press_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_P  = 300,
    parameter int LONG_MIN_T  = 5000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pressed,
    output logic held_long,
    output logic short_evt,
    output logic long_evt
);

    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_P);
    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_MIN_T);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    press_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             short_n, long_evt_n;

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt + ONE_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        short_n    = 1'b0;
        long_evt_n = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    // The first high sample already counts; a one-sample debounce accepts at once.
                    cnt_n   = ONE_C;
                    state_n = (DEB_C == ONE_C) ? HELD : DEBOUNCE;
                end else begin
                    cnt_n = '0;
                end
            end
            DEBOUNCE: begin
                if (!s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DEB_C) state_n = HELD;
                end
            end
            HELD: begin
                if (s) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == LONG_C) state_n = LONG;
                end else begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    short_n = 1'b1;
                end
            end
            LONG: begin
                if (!s) begin
                    state_n    = RELEASE;
                    cnt_n      = '0;
                    long_evt_n = 1'b1;
                end
            end
            RELEASE: begin
                // Any high sample here is bounce: restart the low run, never re-press.
                if (s) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DEB_C) state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pressed   <= 1'b0;
            held_long <= 1'b0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pressed   <= (state_n == HELD) || (state_n == LONG);
            held_long <= (state_n == LONG);
            short_evt <= short_n;
            long_evt  <= long_evt_n;
        end
    end

endmodule

// File: rtl/press_classifier_mc.sv
// press_classifier_mc: N-channel push-button front end; synchronises, debounces and
// classifies each press as SHORT or LONG, pulsing one event per press on release.
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   btn_i        raw asynchronous button levels, 1 = pushed
//   pressed_o    debounced level per channel (HELD or LONG)
//   long_o       1 while a channel's press has reached LONG
//   short_evt_o  1-cycle pulse per released SHORT press
//   long_evt_o   1-cycle pulse per released LONG press
module press_classifier_mc
    import press_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_P  = 300,
    parameter int LONG_MIN_T  = 5000,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] pressed_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] short_evt_o,
    output logic [N_CH-1:0] long_evt_o
);

    if (!press_params_ok(SYNC_STAGES, DEBOUNCE_P, LONG_MIN_T, CNT_W)) begin : g_bad_params
        $error("press_classifier_mc: need SYNC_STAGES>=2 and 1 <= DEBOUNCE_P < LONG_MIN_T < 2**CNT_W");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        press_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_P  (DEBOUNCE_P),
            .LONG_MIN_T  (LONG_MIN_T),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn       (btn_i[i]),
            .pressed   (pressed_o[i]),
            .held_long (long_o[i]),
            .short_evt (short_evt_o[i]),
            .long_evt  (long_evt_o[i])
        );
    end

endmodule

// File: tb/tb_press_classifier_mc.sv
module tb_press_classifier_mc;

    localparam int N_CH = 2;
    localparam int SYNC = 2;
    localparam int P    = 4;
    localparam int L    = 20;
    localparam int W    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] pressed, long_s, short_evt, long_evt;

    always #5 clk = ~clk;

    press_classifier_mc #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_P  (P),
        .LONG_MIN_T  (L),
        .CNT_W       (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn),
        .pressed_o   (pressed),
        .long_o      (long_s),
        .short_evt_o (short_evt),
        .long_evt_o  (long_evt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: run-length view of the synchronised input per channel.
    logic [N_CH-1:0] dly [SYNC];
    int  hi_run [N_CH];   // consecutive high synced samples
    int  rel_lo [N_CH];   // consecutive lows seen since the releasing sample
    bit  acc    [N_CH];   // press accepted and not yet released
    bit  rdy    [N_CH];   // channel free to accept a new press
    logic [N_CH-1:0] e_pressed, e_long, e_short, e_levt;

    // Observed event counts and cross-channel coincidence flag.
    int n_short [N_CH];
    int n_long  [N_CH];
    bit coinc;

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            hi_run[ch] = 0;
            rel_lo[ch] = 0;
            acc[ch]    = 1'b0;
            rdy[ch]    = 1'b1;
        end
        for (int k = 0; k < SYNC; k++) dly[k] = '0;
        e_pressed = '0;
        e_long    = '0;
        e_short   = '0;
        e_levt    = '0;
    endtask

    task automatic model_step();
        logic [N_CH-1:0] s;
        int prev;
        s = dly[SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) dly[k] = dly[k-1];
        dly[0]  = btn;
        e_short = '0;
        e_levt  = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            prev = hi_run[ch];
            if (s[ch]) begin
                if (hi_run[ch] < 1000000) hi_run[ch]++;
            end else begin
                hi_run[ch] = 0;
            end
            if (acc[ch]) begin
                if (!s[ch]) begin
                    if (prev >= L) e_levt[ch] = 1'b1;
                    else           e_short[ch] = 1'b1;
                    acc[ch]    = 1'b0;
                    rel_lo[ch] = 0;
                end
            end else if (!rdy[ch]) begin
                if (s[ch]) rel_lo[ch] = 0;
                else begin
                    rel_lo[ch]++;
                    if (rel_lo[ch] >= P) rdy[ch] = 1'b1;
                end
            end else if (s[ch] && hi_run[ch] >= P) begin
                acc[ch] = 1'b1;
                rdy[ch] = 1'b0;
            end
            e_pressed[ch] = acc[ch];
            e_long[ch]    = acc[ch] && (hi_run[ch] >= L);
        end
    endtask

    task automatic check(input string tag, input logic [N_CH-1:0] got, input logic [N_CH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("pressed", pressed, e_pressed);
        check("long", long_s, e_long);
        check("short_evt", short_evt, e_short);
        check("long_evt", long_evt, e_levt);
        for (int ch = 0; ch < N_CH; ch++) begin
            if (short_evt[ch]) n_short[ch]++;
            if (long_evt[ch])  n_long[ch]++;
        end
        if (short_evt[0] && long_evt[1]) coinc = 1'b1;
    endtask

    task automatic run(input logic [N_CH-1:0] v, input int n);
        btn = v;
        repeat (n) tick();
    endtask

    initial begin
        int rem [N_CH];
        logic [N_CH-1:0] lvl;

        for (int ch = 0; ch < N_CH; ch++) begin
            n_short[ch] = 0;
            n_long[ch]  = 0;
            rem[ch]     = 0;
        end
        coinc = 1'b0;
        btn   = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        check("rst_pressed", pressed, '0);
        check("rst_long", long_s, '0);
        check("rst_short_evt", short_evt, '0);
        check("rst_long_evt", long_evt, '0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Glitch shorter than the debounce window.
        run(2'b01, 3);
        run(2'b00, 12);
        check_int("glitch_short", n_short[0], 0);
        check_int("glitch_long", n_long[0], 0);

        // Short press.
        run(2'b01, 10);
        run(2'b00, 12);
        check_int("short10", n_short[0], 1);

        // Classification boundary: 19 -> SHORT, 20 -> LONG, 300 -> one LONG.
        run(2'b01, 19);
        run(2'b00, 12);
        check_int("short19", n_short[0], 2);
        check_int("short19_nolong", n_long[0], 0);
        run(2'b01, 20);
        run(2'b00, 12);
        check_int("long20", n_long[0], 1);
        run(2'b01, 300);
        run(2'b00, 12);
        check_int("long300", n_long[0], 2);
        check_int("long300_noshort", n_short[0], 2);

        // Bounce in RELEASE, then a press after only 3 lows is still ignored.
        run(2'b01, 10);
        run(2'b00, 1);
        run(2'b01, 1);
        run(2'b00, 1);
        run(2'b01, 1);
        run(2'b00, 3);
        run(2'b01, 10);
        run(2'b00, 12);
        check_int("bounce_one_evt", n_short[0], 3);
        run(2'b01, 10);
        run(2'b00, 12);
        check_int("clean_after_bounce", n_short[0], 4);

        // Asynchronous reset while LONG.
        run(2'b01, 25);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pressed", pressed, '0);
        check("arst_long", long_s, '0);
        check("arst_short_evt", short_evt, '0);
        check("arst_long_evt", long_evt, '0);
        btn = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        run(2'b00, 12);
        check_int("arst_no_long", n_long[0], 2);
        check_int("arst_no_short", n_short[0], 4);

        // Two channels released on the same cycle.
        run(2'b10, 15);
        run(2'b11, 10);
        run(2'b00, 12);
        check_int("dual_short0", n_short[0], 5);
        check_int("dual_long1", n_long[1], 1);
        check_int("dual_short1", n_short[1], 0);
        check_int("dual_coinc", int'(coinc), 1);

        // Randomised run lengths on both channels.
        lvl = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (rem[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    case ($urandom_range(0, 3))
                        0:       rem[ch] = $urandom_range(1, 3);
                        1:       rem[ch] = $urandom_range(4, 19);
                        2:       rem[ch] = $urandom_range(20, 30);
                        default: rem[ch] = $urandom_range(1, 6);
                    endcase
                end
                rem[ch]--;
            end
            btn = lvl;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
